dbg_scan_checker: RTL and testbench
===================================

Name: dbg_scan_checker

Overview:
Synthesizable successor to the bench-side register dump. It sweeps the core's debug read port (address → value_o) over a configurable window and streams every read value out on a valid/ready channel. It also compares each read against an internally loaded golden table under a per-entry bit mask, and reports pass/fail, the error count and the first mismatch. It sits beside Top, driving Top's address input and sampling value_o, so register/memory checks run on silicon or FPGA without a testbench.

Parameters:
DATA_W, 32, width of debug read data and golden entries
ADDR_W, 10, width of debug address
NUM_ENTRIES, 32, number of locations scanned (≥1)
BASE_ADDR, 0, first debug address scanned
RD_LAT, 0, cycles from dbg_addr change to valid dbg_value (0 means combinational)
ERR_W, 8, width of error counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a scan when idle
abort  in  1  single-cycle pulse; cancels a scan in progress
gld_we  in  1  golden table write strobe
gld_idx  in  $clog2(NUM_ENTRIES)  golden table write index
gld_data  in  DATA_W  expected value
gld_mask  in  DATA_W  compare mask (1 = bit checked)
dbg_addr  out  ADDR_W  to Top.address
dbg_value  in  DATA_W  from Top.value_o
dump_valid  out  1  dump beat valid
dump_ready  in  1  downstream accepts beat
dump_idx  out  $clog2(NUM_ENTRIES)  entry index of beat
dump_data  out  DATA_W  value read
dump_err  out  1  beat mismatched golden under mask
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan completion
pass  out  1  last completed scan had zero errors
err_cnt  out  ERR_W  mismatches in last/current scan, saturating at all-ones
first_err_idx  out  $clog2(NUM_ENTRIES)  index of first mismatch
first_err_got  out  DATA_W  value read at first mismatch
first_err_exp  out  DATA_W  golden at first mismatch

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE. All outputs 0: dbg_addr=BASE_ADDR, pass=0. Golden data and mask are not reset.
- FSM states: IDLE, WAIT, EMIT, DONE.
- IDLE + start: clear err_cnt and first_err_* and the first-error flag; idx=0; dbg_addr=BASE_ADDR; wait counter=0; go to WAIT; busy=1 from the next cycle. start while busy is ignored.
- WAIT: dbg_addr is held as a registered value. When the wait counter equals RD_LAT, capture dbg_value into dump_data and compute mismatch = ((dbg_value ^ gold[idx]) & mask[idx]) != 0. Update err_cnt (saturating) and, on the first mismatch only, first_err_*. Go to EMIT. Otherwise increment the counter.
- EMIT: dump_valid=1. dump_idx, dump_data and dump_err stay stable until dump_ready. On the handshake: if idx==NUM_ENTRIES-1, go to DONE; else idx+1, dbg_addr+1 (wraps modulo 2^ADDR_W), counter=0, go to WAIT.
- DONE: for one cycle, done=1, pass=(err_cnt==0), busy=0 afterwards; return to IDLE. Results hold until the next start.
- Timing: with RD_LAT=0 and dump_ready tied high, each entry takes 2 cycles and done asserts 2*NUM_ENTRIES+1 cycles after start. Each extra RD_LAT cycle adds 1 cycle per entry.
- abort: takes priority over start/handshake in any non-IDLE state. Go to IDLE the next cycle, drop dump_valid, no done, pass unchanged. Partial err_cnt remains visible.
- Golden table: gld_we is accepted only in IDLE and ignored while busy. The write is visible to a scan started the following cycle.
- Mask all-zero entry: never mismatches.
- err_cnt saturates at 2^ERR_W-1 and never wraps.

Decomposition:
- Shared package dbg_scan_pkg: FSM state enum (IDLE, WAIT, EMIT, DONE) and the index width function.
- One sub-module, dbg_golden_ram: NUM_ENTRIES x (2*DATA_W) register array with one write port and one combinational read port, indexed by idx.

Test Plan:
- RD_LAT=0, NUM_ENTRIES=32, Top regs r[i]=i*3, golden matches, mask all-ones, dump_ready=1, start → 32 beats with dump_data=i*3, done at cycle 65, pass=1, err_cnt=0.
- Golden[5]=0xDEAD_BEEF while r5=0x0000_000F → err_cnt=1, first_err_idx=5, first_err_got=0xF, first_err_exp=0xDEADBEEF, pass=0; then mask[5]=0 → rescan gives pass=1.
- RD_LAT=2 with a 2-cycle delayed model of value_o → correct data for all beats, done at cycle 4*32+1 after start.
- dump_ready toggled 1-0-0-1 → beats held stable while ready=0, no beat lost or duplicated, indices 0..31 in order.
- abort at beat 10 → dump_valid low the next cycle, no done, busy=0; gld_we during busy ignored (golden unchanged on readback scan).
- ERR_W=2 with 6 mismatches → err_cnt=3 saturated; async rst mid-scan → all outputs 0 immediately, dbg_addr=BASE_ADDR.

Source files
------------

// File: rtl/dbg_scan_pkg.sv
// Shared types for the debug scan checker: scan FSM states and index sizing.
package dbg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } scan_state_e;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbg_golden_ram.sv
// Golden table: one {mask, data} word per scanned entry.
// It has one clocked write port and one combinational read port.
module dbg_golden_ram #(
    parameter int DATA_W      = 32,
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_W       = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rmask
);

    logic [2*DATA_W-1:0] mem_q [NUM_ENTRIES];

    // NOTE: the table holds configuration loaded by software, not control state, so it has no reset.
    always_ff @(posedge clk) begin
        if (we && (int'(widx) < NUM_ENTRIES)) begin
            mem_q[widx] <= {wmask, wdata};
        end
    end

    always_comb begin
        rdata = '0;
        rmask = '0;
        if (int'(ridx) < NUM_ENTRIES) begin
            {rmask, rdata} = mem_q[ridx];
        end
    end

endmodule

// File: rtl/dbg_scan_checker.sv
// Sweeps the debug read port over a window and streams each value on a valid/ready channel.
// Each value is also compared against a masked golden table; the first mismatch is recorded.
module dbg_scan_checker
    import dbg_scan_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int NUM_ENTRIES = 32,
    parameter int BASE_ADDR   = 0,
    parameter int RD_LAT      = 0,
    parameter int ERR_W       = 8,
    localparam int IDX_W      = idx_w(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              gld_we,
    input  logic [IDX_W-1:0]  gld_idx,
    input  logic [DATA_W-1:0] gld_data,
    input  logic [DATA_W-1:0] gld_mask,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_value,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int                CNT_W    = idx_w(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_MAX  = CNT_W'(RD_LAT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              derr_q, derr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              ferr_seen_q, ferr_seen_d;
    logic [IDX_W-1:0]  ferr_idx_q, ferr_idx_d;
    logic [DATA_W-1:0] ferr_got_q, ferr_got_d;
    logic [DATA_W-1:0] ferr_exp_q, ferr_exp_d;
    logic              pass_q, pass_d;

    logic [DATA_W-1:0] gold_data, gold_mask;
    logic              mismatch;
    logic              tbl_we;

    assign tbl_we = gld_we && (state_q == ST_IDLE);

    dbg_golden_ram #(
        .DATA_W      (DATA_W),
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_golden (
        .clk   (clk),
        .we    (tbl_we),
        .widx  (gld_idx),
        .wdata (gld_data),
        .wmask (gld_mask),
        .ridx  (idx_q),
        .rdata (gold_data),
        .rmask (gold_mask)
    );

    assign mismatch = |((dbg_value ^ gold_data) & gold_mask);

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        derr_d      = derr_q;
        err_cnt_d   = err_cnt_q;
        ferr_seen_d = ferr_seen_q;
        ferr_idx_d  = ferr_idx_q;
        ferr_got_d  = ferr_got_q;
        ferr_exp_d  = ferr_exp_q;
        pass_d      = pass_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_cnt_d   = '0;
                        ferr_seen_d = 1'b0;
                        ferr_idx_d  = '0;
                        ferr_got_d  = '0;
                        ferr_exp_d  = '0;
                        idx_d       = '0;
                        addr_d      = BASE;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == LAT_MAX) begin
                        data_d  = dbg_value;
                        derr_d  = mismatch;
                        state_d = ST_EMIT;
                        if (mismatch) begin
                            if (err_cnt_q != ERR_MAX) begin
                                err_cnt_d = err_cnt_q + ERR_W'(1);
                            end
                            if (!ferr_seen_q) begin
                                ferr_seen_d = 1'b1;
                                ferr_idx_d  = idx_q;
                                ferr_got_d  = dbg_value;
                                ferr_exp_d  = gold_data;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (dump_ready) begin
                        if (idx_q == LAST_IDX) begin
                            // Verdict is latched on entry so it is valid alongside the done pulse.
                            pass_d  = (err_cnt_q == '0);
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            addr_d  = addr_q + ADDR_W'(1);
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            addr_q      <= BASE;
            cnt_q       <= '0;
            data_q      <= '0;
            derr_q      <= 1'b0;
            err_cnt_q   <= '0;
            ferr_seen_q <= 1'b0;
            ferr_idx_q  <= '0;
            ferr_got_q  <= '0;
            ferr_exp_q  <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            derr_q      <= derr_d;
            err_cnt_q   <= err_cnt_d;
            ferr_seen_q <= ferr_seen_d;
            ferr_idx_q  <= ferr_idx_d;
            ferr_got_q  <= ferr_got_d;
            ferr_exp_q  <= ferr_exp_d;
            pass_q      <= pass_d;
        end
    end

    assign dbg_addr      = addr_q;
    assign dump_valid    = (state_q == ST_EMIT);
    assign dump_idx      = idx_q;
    assign dump_data     = data_q;
    assign dump_err      = derr_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = ferr_idx_q;
    assign first_err_got = ferr_got_q;
    assign first_err_exp = ferr_exp_q;

endmodule

// File: tb/tb_dbg_scan_checker.sv
// Self-checking bench: two checker instances (combinational read port at base 0,
// and a 2-cycle read port at base 1020 with a 2-bit error counter) against a scan-level model.
module tb_dbg_scan_checker;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        start, abort, gld_we, dump_ready;
    logic [4:0]  gld_idx;
    logic [31:0] gld_data, gld_mask;

    logic [9:0]  dbg_addr0, dbg_addr2;
    logic [31:0] dbg_value0, dbg_value2;
    logic        dump_valid0, dump_valid2, dump_err0, dump_err2;
    logic [4:0]  dump_idx0, dump_idx2, fidx0, fidx2;
    logic [31:0] dump_data0, dump_data2, fgot0, fgot2, fexp0, fexp2;
    logic        busy0, busy2, done0, done2, pass0, pass2;
    logic [7:0]  err_cnt0;
    logic [1:0]  err_cnt2;

    logic [31:0] top_regs [1024];
    logic [31:0] gold [2][N];
    logic [31:0] mask [2][N];
    logic [9:0]  a2_d1, a2_d2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for Top: combinational read for instance 0, 2-cycle pipelined read for instance 2.
    assign dbg_value0 = top_regs[dbg_addr0];
    always @(posedge clk) begin
        a2_d1 <= dbg_addr2;
        a2_d2 <= a2_d1;
    end
    assign dbg_value2 = top_regs[a2_d2];

    dbg_scan_checker #(
        .DATA_W(32), .ADDR_W(10), .NUM_ENTRIES(N), .BASE_ADDR(0), .RD_LAT(0), .ERR_W(8)
    ) u0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
        .gld_we(gld_we & ~sel), .gld_idx(gld_idx), .gld_data(gld_data), .gld_mask(gld_mask),
        .dbg_addr(dbg_addr0), .dbg_value(dbg_value0),
        .dump_valid(dump_valid0), .dump_ready(dump_ready), .dump_idx(dump_idx0),
        .dump_data(dump_data0), .dump_err(dump_err0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
        .first_err_idx(fidx0), .first_err_got(fgot0), .first_err_exp(fexp0)
    );

    dbg_scan_checker #(
        .DATA_W(32), .ADDR_W(10), .NUM_ENTRIES(N), .BASE_ADDR(1020), .RD_LAT(2), .ERR_W(2)
    ) u2 (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
        .gld_we(gld_we & sel), .gld_idx(gld_idx), .gld_data(gld_data), .gld_mask(gld_mask),
        .dbg_addr(dbg_addr2), .dbg_value(dbg_value2),
        .dump_valid(dump_valid2), .dump_ready(dump_ready), .dump_idx(dump_idx2),
        .dump_data(dump_data2), .dump_err(dump_err2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err_idx(fidx2), .first_err_got(fgot2), .first_err_exp(fexp2)
    );

    // Currently selected instance, as seen by the checks.
    wire [9:0]  c_addr  = sel ? dbg_addr2   : dbg_addr0;
    wire        c_valid = sel ? dump_valid2 : dump_valid0;
    wire [4:0]  c_idx   = sel ? dump_idx2   : dump_idx0;
    wire [31:0] c_data  = sel ? dump_data2  : dump_data0;
    wire        c_derr  = sel ? dump_err2   : dump_err0;
    wire        c_busy  = sel ? busy2       : busy0;
    wire        c_done  = sel ? done2       : done0;
    wire        c_pass  = sel ? pass2       : pass0;
    wire [7:0]  c_err   = sel ? {6'd0, err_cnt2} : err_cnt0;
    wire [4:0]  c_fidx  = sel ? fidx2       : fidx0;
    wire [31:0] c_fgot  = sel ? fgot2       : fgot0;
    wire [31:0] c_fexp  = sel ? fexp2       : fexp0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int base_of(input int s);
        return (s != 0) ? 1020 : 0;
    endfunction

    function automatic logic [31:0] reg_at(input int s, input int i);
        return top_regs[(base_of(s) + i) % 1024];
    endfunction

    function automatic bit model_mism(input int s, input int i);
        return ((reg_at(s, i) ^ gold[s][i]) & mask[s][i]) != 32'd0;
    endfunction

    // Expected error count over entries 0..last, saturated at the instance's counter maximum.
    function automatic int model_errs(input int s, input int last);
        int n = 0;
        int sat = (s != 0) ? 3 : 255;
        for (int i = 0; i <= last; i++) if (model_mism(s, i)) n++;
        return (n > sat) ? sat : n;
    endfunction

    function automatic int model_first(input int s);
        for (int i = 0; i < N; i++) if (model_mism(s, i)) return i;
        return -1;
    endfunction

    task automatic write_gold(input int i, input logic [31:0] d, input logic [31:0] m);
        @(negedge clk);
        gld_we = 1'b1; gld_idx = 5'(i); gld_data = d; gld_mask = m;
        @(negedge clk);
        gld_we = 1'b0;
        gold[sel][i] = d;
        mask[sel][i] = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  c_busy,  0);
        check({tag, "_valid"}, c_valid, 0);
        check({tag, "_done"},  c_done,  0);
        check({tag, "_pass"},  c_pass,  0);
        check({tag, "_err"},   c_err,   0);
        check({tag, "_fidx"},  c_fidx,  0);
        check({tag, "_fgot"},  c_fgot,  0);
        check({tag, "_fexp"},  c_fexp,  0);
        check({tag, "_data"},  c_data,  0);
        check({tag, "_addr"},  c_addr,  base_of(sel));
    endtask

    // One scan on the selected instance. ready_mode 1 drives dump_ready 1-0-0-1;
    // abort_at >= 0 aborts on that beat; wr_at/rst_at fire a golden write / async reset on that cycle.
    task automatic run_scan(input string tag, input int ready_mode, input int abort_at,
                            input int wr_at, input int rst_at);
        int k = 1;
        int exp_i = 0;
        int lat = (sel != 0) ? 2 : 0;
        int fe;
        bit finished = 0;
        bit done_seen = 0;
        bit hold = 0;
        bit rdy;
        logic        prev_pass;
        logic [4:0]  h_idx;
        logic [31:0] h_data;
        logic        h_err;
        prev_pass = c_pass;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && k < 400) begin
            if (hold) begin
                check({tag, "_hold_valid"}, c_valid, 1);
                check({tag, "_hold_idx"},   c_idx,   h_idx);
                check({tag, "_hold_data"},  c_data,  h_data);
                check({tag, "_hold_err"},   c_derr,  h_err);
            end
            if (k == 1) check({tag, "_busy_start"}, c_busy, 1);
            if (k == rst_at) begin
                #2 rst = 1'b0;
                #1 check_reset_outputs({tag, "_rst"});
                @(negedge clk);
                rst = 1'b1;
                finished = 1;
            end else if (c_done) begin
                done_seen = 1;
                finished = 1;
                if (ready_mode == 0) check({tag, "_done_cycle"}, k, (lat + 2) * N + 1);
                check({tag, "_beats"}, exp_i, N);
                check({tag, "_err_cnt"}, c_err, model_errs(sel, N - 1));
                check({tag, "_pass"}, c_pass, model_errs(sel, N - 1) == 0);
                fe = model_first(sel);
                check({tag, "_first_idx"}, c_fidx, (fe < 0) ? 0 : fe);
                check({tag, "_first_got"}, c_fgot, (fe < 0) ? 32'd0 : reg_at(sel, fe));
                check({tag, "_first_exp"}, c_fexp, (fe < 0) ? 32'd0 : gold[sel][fe]);
            end else if (c_valid && exp_i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({tag, "_abort_valid"}, c_valid, 0);
                check({tag, "_abort_busy"},  c_busy,  0);
                check({tag, "_abort_done"},  c_done,  0);
                check({tag, "_abort_err"},   c_err,   model_errs(sel, abort_at));
                check({tag, "_abort_pass"},  c_pass,  prev_pass);
                finished = 1;
            end else begin
                rdy = (ready_mode == 0) || (k % 4 == 0) || (k % 4 == 3);
                dump_ready = rdy;
                if (k == wr_at) begin
                    gld_we = 1'b1; gld_idx = 5'd3; gld_data = ~gold[sel][3]; gld_mask = '1;
                end else begin
                    gld_we = 1'b0;
                end
                if (c_valid && rdy) begin
                    check({tag, "_idx"},  c_idx,  exp_i);
                    check({tag, "_data"}, c_data, reg_at(sel, exp_i));
                    check({tag, "_derr"}, c_derr, model_mism(sel, exp_i));
                    check({tag, "_addr"}, c_addr, (base_of(sel) + exp_i) % 1024);
                    exp_i++;
                    hold = 0;
                end else if (c_valid) begin
                    hold = 1; h_idx = c_idx; h_data = c_data; h_err = c_derr;
                end else begin
                    hold = 0;
                end
                @(negedge clk);
                k++;
            end
        end
        gld_we = 1'b0;
        dump_ready = 1'b1;
        if (!finished) check({tag, "_timeout"}, 0, 1);
        if (done_seen) begin
            @(negedge clk);
            check({tag, "_busy_after"}, c_busy, 0);
            check({tag, "_done_after"}, c_done, 0);
        end
    endtask

    task automatic load_matching_gold();
        for (int i = 0; i < N; i++) write_gold(i, reg_at(sel, i), 32'hFFFF_FFFF);
    endtask

    initial begin
        int bad [6] = '{2, 7, 8, 15, 20, 31};
        rst = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0; gld_we = 1'b0;
        dump_ready = 1'b1; gld_idx = '0; gld_data = '0; gld_mask = '0;
        for (int i = 0; i < 1024; i++) top_regs[i] = 32'(i * 3);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_u0");
        sel = 1'b1;
        #1 check_reset_outputs("reset_u2");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Matching golden table, ready always high.
        load_matching_gold();
        run_scan("basic", 0, -1, -1, -1);
        check("basic_pass_const", c_pass, 1);

        // Single corrupted golden entry.
        write_gold(5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        run_scan("golden5", 0, -1, -1, -1);
        check("golden5_err_const", c_err, 1);
        check("golden5_fidx_const", c_fidx, 5);
        check("golden5_fgot_const", c_fgot, 32'h0000_000F);
        check("golden5_fexp_const", c_fexp, 32'hDEAD_BEEF);
        check("golden5_pass_const", c_pass, 0);

        // Masking the bad entry clears the failure.
        write_gold(5, 32'hDEAD_BEEF, 32'h0000_0000);
        run_scan("mask5", 0, -1, -1, -1);
        check("mask5_pass_const", c_pass, 1);

        // Random registers, sparse bit flips, mixed masks, throttled ready.
        for (int i = 0; i < N; i++) top_regs[i] = $urandom;
        for (int i = 0; i < N; i++) begin
            logic [31:0] g = top_regs[i];
            logic [31:0] m;
            int r = $urandom_range(3);
            if ($urandom_range(3) == 0) g = g ^ (32'd1 << $urandom_range(31));
            m = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF : 32'($urandom);
            write_gold(i, g, m);
        end
        run_scan("random", 1, -1, -1, -1);

        // Abort at beat 10 with a golden write attempted while busy, then a readback scan.
        run_scan("abort", 0, 10, 3, -1);
        run_scan("readback", 0, -1, -1, -1);

        // Second instance: 2-cycle read latency, window wrapping past address 1023.
        sel = 1'b1;
        for (int i = 0; i < N; i++) top_regs[(1020 + i) % 1024] = $urandom;
        load_matching_gold();
        run_scan("lat2", 0, -1, -1, -1);
        check("lat2_pass_const", c_pass, 1);

        for (int j = 0; j < 6; j++) write_gold(bad[j], ~reg_at(1, bad[j]), 32'hFFFF_FFFF);
        run_scan("sat", 0, -1, -1, -1);
        check("sat_err_const", c_err, 3);
        check("sat_fidx_const", c_fidx, 2);

        load_matching_gold();
        run_scan("lat2_again", 0, -1, -1, -1);
        for (int j = 0; j < 6; j++) write_gold(bad[j], ~reg_at(1, bad[j]), 32'hFFFF_FFFF);
        run_scan("midrst", 0, -1, -1, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
